// File: rtl/display_pkg.sv
// Shared constants for the two-digit 7-segment display path: segment patterns
// ({g,f,e,d,c,b,a}, active-high), digit-select encodings and the default refresh divider.
package display_pkg;

    localparam int DEFAULT_REFRESH_DIV = 16;

    localparam logic DIGIT_UNITS = 1'b0;
    localparam logic DIGIT_TENS  = 1'b1;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD digit to 7-segment pattern; invalid codes 10..15 show a dash.
// Purely combinational, zero latency.
module bcd_to_seg7
    import display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_mux_driver.sv
// Holds a captured two-digit BCD value and time-multiplexes it onto one 7-segment bus.
// Capture latency one edge; each digit shown for REFRESH_DIV cycles; no backpressure.
module seg7_mux_driver
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV,
    parameter int CNT_BITS    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] ten_count,
    input  logic [3:0] unit_count,
    input  logic       blank_lz,
    output logic [6:0] segments,
    output logic       digit
);

    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(REFRESH_DIV - 1);

    logic [3:0]          disp_tens;
    logic [3:0]          disp_units;
    logic [CNT_BITS-1:0] cnt;
    logic [3:0]          sel_val;
    logic [6:0]          sel_seg;

    // Display register: only the strobe updates it, so the panel stays stable between loads.
    always_ff @(posedge clk) begin
        if (reset) begin
            disp_tens  <= 4'd0;
            disp_units <= 4'd0;
        end else if (load) begin
            disp_tens  <= ten_count;
            disp_units <= unit_count;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            digit <= DIGIT_UNITS;
        end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            digit <= ~digit;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

    assign sel_val = (digit == DIGIT_TENS) ? disp_tens : disp_units;

    bcd_to_seg7 u_dec (
        .bcd (sel_val),
        .seg (sel_seg)
    );

    // Blanking uses the live blank_lz input; only a zero tens digit is ever suppressed.
    always_comb begin
        segments = sel_seg;
        if (digit == DIGIT_TENS && blank_lz && disp_tens == 4'd0) begin
            segments = SEG_BLANK;
        end
    end

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Randomised and directed bench for seg7_mux_driver against a behavioural display model.
module tb_seg7_mux_driver;

    localparam int RD = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load = 1'b0;
    logic [3:0] ten_count = 4'd0;
    logic [3:0] unit_count = 4'd0;
    logic       blank_lz = 1'b0;
    logic [6:0] segments;
    logic       digit;

    int tests = 0;
    int fails = 0;

    seg7_mux_driver #(.REFRESH_DIV(RD), .CNT_BITS(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .ten_count  (ten_count),
        .unit_count (unit_count),
        .blank_lz   (blank_lz),
        .segments   (segments),
        .digit      (digit)
    );

    always #5 clk = ~clk;

    // Behavioural model: held value plus count of non-reset edges since reset.
    int   m_tens = 0;
    int   m_units = 0;
    int   k = 0;
    logic chk = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_tens  = 0;
            m_units = 0;
            k       = 0;
        end else begin
            if (load) begin
                m_tens  = int'(ten_count);
                m_units = int'(unit_count);
            end
            k = k + 1;
        end
    end

    function automatic logic [6:0] glyph(input int v);
        logic [6:0] tbl [10];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        if (v > 9) return 7'h40;
        return tbl[v];
    endfunction

    function automatic logic exp_digit();
        return logic'((k / RD) % 2);
    endfunction

    function automatic logic [6:0] exp_seg();
        if (exp_digit()) begin
            if (blank_lz && m_tens == 0) return 7'h00;
            return glyph(m_tens);
        end
        return glyph(m_units);
    endfunction

    always @(negedge clk) begin
        if (chk) begin
            tests++;
            if (digit !== exp_digit()) begin
                fails++;
                $display("FAIL model_digit t=%0t got %b want %b", $time, digit, exp_digit());
            end
            tests++;
            if (segments !== exp_seg()) begin
                fails++;
                $display("FAIL model_segments t=%0t got %h want %h", $time, segments, exp_seg());
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [6:0] got, input logic [6:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic wait_digit(input logic val, input string name);
        int n = 0;
        while (digit !== val && n < 3 * RD) begin
            step();
            n++;
        end
        if (digit !== val) begin
            tests++;
            fails++;
            $display("FAIL %s timeout waiting for digit=%b", name, val);
        end
    endtask

    task automatic do_load(input logic [3:0] t, input logic [3:0] u);
        load = 1'b1;
        ten_count = t;
        unit_count = u;
        step();
        load = 1'b0;
    endtask

    initial begin
        int n;
        step();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk = 1'b1;

        // 1: reset state and refresh period
        check("reset_digit", {6'd0, digit}, 7'd0);
        check("reset_segments", segments, 7'h3F);
        n = 0;
        while (digit !== 1'b1 && n < 100) begin step(); n++; end
        check("first_toggle_cycles", 7'(n), 7'd16);
        n = 0;
        while (digit !== 1'b0 && n < 100) begin step(); n++; end
        check("second_toggle_cycles", 7'(n), 7'd16);

        // 2: held value survives input changes
        do_load(4'd4, 4'd2);
        ten_count = 4'd9;
        unit_count = 4'd9;
        for (int i = 0; i < 100; i++) begin
            check("hold_42", segments, digit ? 7'h66 : 7'h5B);
            step();
        end

        // 3: leading-zero blanking, applied live
        blank_lz = 1'b1;
        do_load(4'd0, 4'd7);
        wait_digit(1'b1, "blank_tens");
        check("blank_tens", segments, 7'h00);
        blank_lz = 1'b0;
        step();
        check("unblank_tens", segments, 7'h3F);
        wait_digit(1'b0, "blank_units");
        check("blank_units", segments, 7'h07);

        // 4: invalid BCD dash
        do_load(4'd12, 4'd3);
        wait_digit(1'b1, "dash_tens");
        check("dash_tens", segments, 7'h40);
        wait_digit(1'b0, "dash_units");
        check("dash_units", segments, 7'h4F);

        // 5: load coincident with units->tens toggle
        n = 0;
        while (!(digit == 1'b0 && (k % (2 * RD)) == RD - 1) && n < 4 * RD) begin step(); n++; end
        do_load(4'd8, 4'd1);
        check("toggle_load_digit", {6'd0, digit}, 7'd1);
        check("toggle_load_seg", segments, 7'h7F);

        // Randomised traffic, including occasional resets
        for (int i = 0; i < 2000; i++) begin
            load = ($urandom_range(3) == 0);
            ten_count = 4'($urandom_range(15));
            unit_count = 4'($urandom_range(15));
            if ($urandom_range(7) == 0) blank_lz = ~blank_lz;
            reset = ($urandom_range(199) == 0);
            step();
        end
        reset = 1'b0;
        load = 1'b0;

        // 6: reset mid-frame beats a simultaneous load
        do_load(4'd6, 4'd6);
        repeat (5) step();
        blank_lz = 1'b0;
        reset = 1'b1;
        load = 1'b1;
        ten_count = 4'd5;
        unit_count = 4'd5;
        step();
        reset = 1'b0;
        load = 1'b0;
        check("midreset_digit", {6'd0, digit}, 7'd0);
        check("midreset_units", segments, 7'h3F);
        wait_digit(1'b1, "midreset_tens");
        check("midreset_tens", segments, 7'h3F);
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
